crc_check: RTL
==============

# crc_check

Serial CRC-16 frame receiver and checker. It sits on the receive side of the serial link, opposite the FCS-appending transmitter. It takes one bit per valid cycle: a fixed-length payload followed by a 16-bit FCS. It recomputes CRC-16/X.25 over the payload, compares the received FCS bit by bit, and presents the captured payload with a one-cycle pass or fail verdict.

## Interface
- PAYLOAD_BITS, 80, payload length in bits per frame (8..255).
- TIMEOUT, 32, consecutive idle cycles mid-frame before the frame is aborted (2..255).
- clk  input  1  system clock (10 kHz nominal)
- reset  input  1  synchronous, active-high reset
- rx_in  input  1  serial bit, payload bits first, then FCS, LSB first
- rx_in_valid  input  1  rx_in is sampled on every clk edge where this is high
- payload  output  PAYLOAD_BITS  captured payload; bit 0 is the first bit received; updated only on a good frame
- crc_ok  output  1  one-cycle pulse: frame complete, FCS matched
- crc_err  output  1  one-cycle pulse: FCS mismatch or abort
- frame_abort  output  1  one-cycle pulse, always coincident with crc_err, caused by timeout
- busy  output  1  high while a frame is partially received

## Operation
- States:
  - IDLE: crc=16'hFFFF, bit count 0, error flag 0.
  - DATA: payload bits 0..PAYLOAD_BITS-1.
  - FCS: FCS bits 0..15.
- IDLE -> DATA on the first valid bit. That bit is processed in the same cycle, so the frame has no preamble.
- Each valid payload bit d:
  - fb = crc[0]^d
  - crc <= {fb, crc[15:12], crc[11]^fb, crc[10:5], crc[4]^fb, crc[3:1]}
  - d is shifted into the payload shadow register.
- DATA -> FCS when the valid bit with count == PAYLOAD_BITS-1 is sampled, including that bit's CRC update.
- Each valid FCS bit f:
  - if f != ~crc[0], set the error flag;
  - then crc <= crc >> 1.
- The FCS on the wire is therefore ~crc, sent LSB first.
- On the 16th FCS bit, return to IDLE and re-initialise crc, count and flag.
  - Assert crc_ok (flag clear, including this bit) or crc_err (flag set) in the next cycle.
  - On crc_ok, copy the shadow register to payload. On crc_err, payload holds its old value.
- Stalls: rx_in_valid low in DATA or FCS holds all state and increments an idle counter. Any valid bit clears the idle counter.
- Timeout: when the idle counter reaches TIMEOUT, return to IDLE and pulse crc_err and frame_abort in the next cycle. Bits already received are discarded.
- busy is high in DATA and FCS.

## Timing
- Reset (synchronous, highest priority, legal mid-frame):
  - payload=0, crc_ok=0, crc_err=0, frame_abort=0, busy=0;
  - state IDLE, crc=16'hFFFF;
  - a frame in flight is dropped with no pulse.
- Verdict latency: pulse is asserted in the cycle after the edge that samples FCS bit 15. payload is valid from the same cycle.
- Back-to-back frames: a valid bit in the verdict-pulse cycle is bit 0 of the next frame. Zero-gap streaming is supported.
- Timeout vs. valid bit: if the TIMEOUT-th idle cycle and a valid bit coincide, the bit wins. Because the counter only advances on idle cycles, this is consistent by construction.
- Timeout pulse appears the cycle after the counter reaches TIMEOUT.
- Pulse exclusivity: crc_ok and crc_err are never high together. frame_abort is never high without crc_err.
- Counter widths:
  - bit count: 8 bits;
  - idle counter: 8 bits, saturating;
  - FCS index: 4 bits, wraps 15 -> 0 on frame end.

## Structure
- Shared package crc_pkg:
  - CRC_INIT = 16'hFFFF
  - CRC_POLY_REFL = 16'h8408
  - function crc16_step(crc, bit), for reuse by the transmitter and the bench model
  - state enum {IDLE, DATA, FCS}
- One natural sub-module, crc16_lfsr: init/enable/shift controls plus the serial-update and shift-out datapath.
- crc_check holds the FSM, counters and payload register.

## Test plan
- Known vector: PAYLOAD_BITS=72; ASCII "123456789", each byte LSB first; then FCS 16'h906E LSB first.
  - Internal crc after payload must equal 16'h6F91.
  - crc_ok pulses once.
  - payload[7:0] = 8'h31.
- Corrupt FCS: same frame with FCS bit 7 flipped -> crc_err=1, frame_abort=0, payload unchanged.
- Stalls: same good frame with rx_in_valid low for 31 random cycles between bits (TIMEOUT=32) -> crc_ok.
- Timeout: 40 valid bits then valid low for 32 cycles -> crc_err and frame_abort on the cycle after the 32nd idle cycle. A following good frame still yields crc_ok.
- Back-to-back: two good frames with zero gap -> two crc_ok pulses exactly 88 cycles apart (72+16).
- Reset mid-frame: assert reset during FCS bit 5 -> no pulse, all outputs 0. The next good frame yields crc_ok.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC-16/X.25 definitions for the serial receiver, transmitter and models.
package crc_pkg;

  localparam int unsigned CRC_W     = 16;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned FCS_IDX_W = 4;

  localparam logic [CRC_W-1:0] CRC_INIT      = 16'hFFFF;
  localparam logic [CRC_W-1:0] CRC_POLY_REFL = 16'h8408;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    FCS  = 2'd2
  } state_t;

  // One-cycle verdict pulses presented to the consumer.
  typedef struct packed {
    logic ok;
    logic err;
    logic abort;
  } verdict_t;

  // One reflected CRC-16 step for a single serial data bit.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                  input logic             d);
    logic fb;
    fb = crc[0] ^ d;
    return (crc >> 1) ^ (fb ? CRC_POLY_REFL : CRC_W'(0));
  endfunction

endpackage

// File: rtl/crc16_lfsr.sv
// Serial CRC-16 register: accumulate over payload bits, shift out during the FCS.
module crc16_lfsr
  import crc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_init,
  input  logic             i_en,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] w_crc_next;

  // Next value: re-init wins over update; shift mode consumes the register LSB first.
  always_comb begin
    w_crc_next = r_crc;
    if (i_init) begin
      w_crc_next = CRC_INIT;
    end else if (i_en) begin
      if (i_shift) begin
        w_crc_next = r_crc >> 1;
      end else begin
        w_crc_next = crc16_step(r_crc, i_bit);
      end
    end
  end

  // CRC state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc <= CRC_INIT;
    end else begin
      r_crc <= w_crc_next;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/crc_check.sv
// Serial CRC-16/X.25 frame receiver: payload then FCS, one-cycle pass/fail verdict.
module crc_check
  import crc_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = 80,
  parameter int unsigned TIMEOUT      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_in,
  input  logic                    rx_in_valid,
  output logic [PAYLOAD_BITS-1:0] payload,
  output logic                    crc_ok,
  output logic                    crc_err,
  output logic                    frame_abort,
  output logic                    busy
);

  localparam logic [CNT_W-1:0]     LAST_BIT  = CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [CNT_W-1:0]     IDLE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
  localparam logic [FCS_IDX_W-1:0] FCS_LAST  = FCS_IDX_W'(CRC_W - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [FCS_IDX_W-1:0]    r_fcs_idx;
  logic [CNT_W-1:0]        r_idle_cnt;
  logic                    r_err;
  logic                    r_busy;
  logic [PAYLOAD_BITS-1:0] r_shadow;
  logic [PAYLOAD_BITS-1:0] r_payload;
  verdict_t                r_verdict;

  logic [CRC_W-1:0]        w_crc;
  logic                    w_in_frame;
  logic                    w_stall;
  logic                    w_timeout;
  logic                    w_fcs_bit;
  logic                    w_fcs_end;
  logic                    w_fcs_miss;
  logic                    w_lfsr_init;

  // Frame-level decode shared by the FSM and the CRC register controls.
  always_comb begin
    w_in_frame  = (r_state != IDLE);
    w_stall     = w_in_frame && !rx_in_valid;
    w_timeout   = w_stall && (r_idle_cnt == IDLE_LAST);
    w_fcs_bit   = ~w_crc[0];
    w_fcs_end   = (r_state == FCS) && rx_in_valid && (r_fcs_idx == FCS_LAST);
    w_fcs_miss  = (r_state == FCS) && rx_in_valid && (rx_in != w_fcs_bit);
    w_lfsr_init = w_timeout || w_fcs_end;
  end

  crc16_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_init  (w_lfsr_init),
    .i_en    (rx_in_valid),
    .i_shift (r_state == FCS),
    .i_bit   (rx_in),
    .o_crc   (w_crc)
  );

  // Receive FSM, counters, shadow/payload registers and verdict pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_fcs_idx  <= '0;
      r_idle_cnt <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_shadow   <= '0;
      r_payload  <= '0;
      r_verdict  <= '0;
    end else begin
      r_verdict <= '0;
      if (w_stall) begin
        if (w_timeout) begin
          // Abandon the partial frame; received bits are simply discarded.
          r_state          <= IDLE;
          r_busy           <= 1'b0;
          r_bit_cnt        <= '0;
          r_fcs_idx        <= '0;
          r_idle_cnt       <= '0;
          r_err            <= 1'b0;
          r_verdict.err    <= 1'b1;
          r_verdict.abort  <= 1'b1;
        end else if (r_idle_cnt != CNT_MAX) begin
          r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
      end else if (rx_in_valid) begin
        r_idle_cnt <= '0;
        case (r_state)
          IDLE: begin
            // First valid bit is payload bit 0; no preamble.
            r_state   <= DATA;
            r_busy    <= 1'b1;
            r_bit_cnt <= CNT_W'(1);
            r_shadow  <= {rx_in, r_shadow[PAYLOAD_BITS-1:1]};
          end
          DATA: begin
            r_shadow <= {rx_in, r_shadow[PAYLOAD_BITS-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              r_state   <= FCS;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
          FCS: begin
            r_fcs_idx <= r_fcs_idx + FCS_IDX_W'(1);
            if (r_fcs_idx == FCS_LAST) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b0;
              if (r_err || w_fcs_miss) begin
                r_verdict.err <= 1'b1;
              end else begin
                r_verdict.ok <= 1'b1;
                r_payload    <= r_shadow;
              end
            end else if (w_fcs_miss) begin
              r_err <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign payload     = r_payload;
  assign crc_ok      = r_verdict.ok;
  assign crc_err     = r_verdict.err;
  assign frame_abort = r_verdict.abort;
  assign busy        = r_busy;

endmodule
